pe_alu_share_arbiter: RTL and testbench
=======================================

// Module: pe_alu_share_arbiter
// PURPOSE
//  Shares one multi-cycle ALU functional unit (FU) between processing elements PE1 and PE2.
//  Each PE presents operands plus its decoded 3-bit ALUControl on a valid/ready request port.
//  The arbiter grants requests round-robin and keeps at most one operation outstanding.
//  It launches the FU, waits for completion or timeout, and returns the result to the granted PE.
// PARAMETERS
//  WIDTH         32   operand/result width in bits
//  TIMEOUT_CYC   64   WAIT-state cycles before an operation is aborted; >=2
//  TMR_W         7    timer width; must hold TIMEOUT_CYC-1
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  req1_valid    in   1      PE1 request valid
//  req1_ready    out  1      PE1 request accepted this cycle
//  req1_a/b      in   WIDTH  PE1 operands
//  req1_ctrl     in   3      PE1 ALUControl
//  rsp1_valid    out  1      PE1 response strobe, one cycle
//  rsp1_result   out  WIDTH  PE1 result
//  rsp1_zero     out  1      result == 0
//  rsp1_err      out  1      operation timed out
//  req2_*/rsp2_* (same set)  PE2 equivalents
//  fu_start      out  1      one-cycle launch pulse to the FU
//  fu_a/fu_b     out  WIDTH  latched operands
//  fu_ctrl       out  3      latched ALUControl
//  fu_done       in   1      FU completion pulse
//  fu_result     in   WIDTH  FU result, valid while fu_done=1
//  busy          out  1      state != IDLE
//  grant_id      out  1      0=PE1, 1=PE2; id of the current or last grant
// BEHAVIOUR
//  Reset values: state=IDLE, last_grant=1 (PE1 wins the first tie), timer=0. All outputs 0.
//  In reset, fu_start=0 and all rsp*_valid=0.
//  Reset mid-operation: the operation is abandoned, no response is issued, and any late fu_done is ignored.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - Only one valid: that PE is granted.
//   - Both valid: the PE != last_grant is granted.
//   - reqX_ready is combinational: it is 1 only for the granted PE, only in IDLE.
//   - On the handshake cycle, a/b/ctrl/id are latched and the FSM moves to ISSUE.
//   - The non-granted PE sees ready=0 and must hold valid and operands stable.
//  ISSUE: fu_start=1 for exactly one cycle; fu_a/fu_b/fu_ctrl come from the latches; timer cleared; -> WAIT.
//  fu_a/fu_b/fu_ctrl stay stable from ISSUE until leaving WAIT.
//  WAIT:
//   - fu_done=1: latch fu_result, err=0, -> RESP.
//   - Otherwise timer+1; when timer==TIMEOUT_CYC-1: result=0, err=1, -> RESP.
//   - fu_done in the same cycle as timeout: done wins, err=0.
//  RESP:
//   - rspX_valid=1 for one cycle for the latched id, with result/zero/err.
//   - rsp outputs of the other PE stay 0; responses have no backpressure.
//   - last_grant <= id; -> IDLE.
//  fu_done outside WAIT is ignored.
//  rsp*_result/zero/err hold their last value when valid=0.
//  Latency: handshake at cycle T; fu_start at T+1; earliest fu_done at T+2; rsp at cycle D+1 after fu_done at D.
//  Minimum request-to-request spacing is 4 cycles (next grant can happen in the IDLE cycle after RESP).
//  zero flag = ~|result, computed on the latched value.
// TESTING
//  1. PE1 a=5,b=3,ctrl=001; FU done 3 cycles after start with result 2
//     -> fu_start at T+1; rsp1_valid at T+5, result=2, zero=0, err=0; rsp2_valid stays 0.
//  2. After reset, both PEs valid in the same cycle, each FU op 2 cycles
//     -> PE1 granted first, then PE2; with both held valid, grants alternate 1,2,1,2.
//  3. PE2 continuously valid, PE1 idle, FU done on the cycle after start
//     -> PE2 granted back-to-back every 4 cycles; req2_ready pulses one cycle each time.
//  4. fu_done never asserted, TIMEOUT_CYC=64
//     -> rsp valid 64 cycles after fu_start+1 with err=1, result=0, zero=1; next grant proceeds.
//  5. fu_done=1 with result 0xFF in the timeout cycle -> err=0, result=0xFF.
//     fu_done pulse in IDLE -> no rsp, state unchanged.
//  6. rst asserted during WAIT, then fu_done
//     -> no rsp of any kind; busy=0 next cycle; with both PEs valid afterwards, PE1 is granted first.

Source files
------------

// File: rtl/pe_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pe_alu_share_arbiter
// Description : Shares one multi-cycle ALU functional unit between two
//               processing elements. Requests are granted round-robin with
//               at most one operation outstanding. The FU is launched with a
//               one-cycle start pulse. The arbiter waits for fu_done or a
//               timeout, then returns a one-cycle response to the granted PE.
// Ports       : clk, rst                      - clock, sync active-high reset
//               reqN_valid/ready/a/b/ctrl     - PE N request (valid/ready)
//               rspN_valid/result/zero/err    - PE N response strobe + data
//               fu_start/a/b/ctrl             - FU launch and latched operands
//               fu_done/fu_result             - FU completion and result
//               busy, grant_id                - status: not idle, last grant
// Revision    : 1.0 - initial release
// ============================================================================
module pe_alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int TMR_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    input  logic             req2_valid,
    output logic             req2_ready,
    input  logic [WIDTH-1:0] req2_a,
    input  logic [WIDTH-1:0] req2_b,
    input  logic [2:0]       req2_ctrl,
    output logic             rsp2_valid,
    output logic [WIDTH-1:0] rsp2_result,
    output logic             rsp2_zero,
    output logic             rsp2_err,
    output logic             fu_start,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic [2:0]       fu_ctrl,
    input  logic             fu_done,
    input  logic [WIDTH-1:0] fu_result,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic               r_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_ctrl;
    logic [TMR_W-1:0]   r_timer;
    logic [WIDTH-1:0]   r_rsp1_result;
    logic               r_rsp1_zero;
    logic               r_rsp1_err;
    logic [WIDTH-1:0]   r_rsp2_result;
    logic               r_rsp2_zero;
    logic               r_rsp2_err;

    logic               w_any_valid;
    logic               w_sel_id;
    logic               w_handshake;
    logic               w_timeout;

    // On a tie the PE that did not win last time is chosen; otherwise the
    // single requester wins.
    assign w_any_valid = req1_valid | req2_valid;
    assign w_sel_id    = (req1_valid && req2_valid) ? ~r_last_grant : req2_valid;
    assign w_handshake = (r_state == ST_IDLE) && w_any_valid && !rst;
    assign w_timeout   = (r_timer == C_TMR_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_valid)           w_state_nxt = ST_ISSUE;
            ST_ISSUE:                            w_state_nxt = ST_WAIT;
            ST_WAIT:  if (fu_done || w_timeout)  w_state_nxt = ST_RESP;
            ST_RESP:                             w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_id          <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_ctrl        <= '0;
            r_timer       <= '0;
            r_rsp1_result <= '0;
            r_rsp1_zero   <= 1'b0;
            r_rsp1_err    <= 1'b0;
            r_rsp2_result <= '0;
            r_rsp2_zero   <= 1'b0;
            r_rsp2_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_id   <= w_sel_id;
                        r_a    <= w_sel_id ? req2_a    : req1_a;
                        r_b    <= w_sel_id ? req2_b    : req1_b;
                        r_ctrl <= w_sel_id ? req2_ctrl : req1_ctrl;
                    end
                end
                ST_ISSUE: r_timer <= '0;
                ST_WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    // The per-PE response registers are written only for the
                    // granted PE so the other PE keeps its last response.
                    if (fu_done || w_timeout) begin
                        if (!r_id) begin
                            r_rsp1_result <= fu_done ? fu_result : '0;
                            r_rsp1_zero   <= fu_done ? ~|fu_result : 1'b1;
                            r_rsp1_err    <= ~fu_done;
                        end else begin
                            r_rsp2_result <= fu_done ? fu_result : '0;
                            r_rsp2_zero   <= fu_done ? ~|fu_result : 1'b1;
                            r_rsp2_err    <= ~fu_done;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: r_last_grant <= r_id;
                default: ;
            endcase
        end
    end

    // Strobes are masked while rst is high so nothing leaks out during the
    // reset cycle itself, whatever state the register still holds.
    assign req1_ready  = w_handshake && !w_sel_id;
    assign req2_ready  = w_handshake &&  w_sel_id;
    assign fu_start    = (r_state == ST_ISSUE) && !rst;
    assign rsp1_valid  = (r_state == ST_RESP) && !r_id && !rst;
    assign rsp2_valid  = (r_state == ST_RESP) &&  r_id && !rst;
    assign busy        = (r_state != ST_IDLE) && !rst;
    assign grant_id    = r_id;
    assign fu_a        = r_a;
    assign fu_b        = r_b;
    assign fu_ctrl     = r_ctrl;
    assign rsp1_result = r_rsp1_result;
    assign rsp1_zero   = r_rsp1_zero;
    assign rsp1_err    = r_rsp1_err;
    assign rsp2_result = r_rsp2_result;
    assign rsp2_zero   = r_rsp2_zero;
    assign rsp2_err    = r_rsp2_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_alu_share_arbiter
// Description : Self-checking bench for pe_alu_share_arbiter. The bench plays
//               the FU and both PEs. A transaction-level model tracks the
//               round-robin winner and each PE's last response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_alu_share_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req1_valid, req1_ready, req2_valid, req2_ready;
    logic [W-1:0] req1_a, req1_b, req2_a, req2_b;
    logic [2:0]   req1_ctrl, req2_ctrl;
    logic         rsp1_valid, rsp1_zero, rsp1_err, rsp2_valid, rsp2_zero, rsp2_err;
    logic [W-1:0] rsp1_result, rsp2_result;
    logic         fu_start, fu_done, busy, grant_id;
    logic [W-1:0] fu_a, fu_b, fu_result;
    logic [2:0]   fu_ctrl;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model state
    bit           m_last;
    logic [W-1:0] m_res  [2];
    logic         m_zero [2];
    logic         m_err  [2];

    always #5 clk = ~clk;

    pe_alu_share_arbiter #(.WIDTH(W), .TIMEOUT_CYC(64), .TMR_W(7)) dut (
        .clk(clk), .rst(rst),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_a(req2_a),
        .req2_b(req2_b), .req2_ctrl(req2_ctrl), .rsp2_valid(rsp2_valid),
        .rsp2_result(rsp2_result), .rsp2_zero(rsp2_zero), .rsp2_err(rsp2_err),
        .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b), .fu_ctrl(fu_ctrl),
        .fu_done(fu_done), .fu_result(fu_result), .busy(busy), .grant_id(grant_id)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int pe);
        if (pe == 0) begin
            req1_a = $urandom; req1_b = $urandom; req1_ctrl = 3'($urandom);
        end else begin
            req2_a = $urandom; req2_b = $urandom; req2_ctrl = 3'($urandom);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_res[i] = '0; m_zero[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; req1_valid = 1'b0; req2_valid = 1'b0; fu_done = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
        model_reset();
        step();
    endtask

    // One request/response transaction. dly = cycles from fu_start to the
    // fu_done pulse (1..64); any other value means the FU never answers.
    task automatic run_txn(input bit v1, input bit v2, input int dly,
                           input logic [W-1:0] res, input bit keep, input string tag);
        int           exp_id;
        int           resp_at;
        bit           tmo;
        logic [W-1:0] ea, eb;
        logic [2:0]   ec;
        logic [1:0]   exp_rdy;
        logic [1:0]   exp_rsp;
        if (v1 && !req1_valid) set_ops(0);
        if (v2 && !req2_valid) set_ops(1);
        req1_valid = v1;
        req2_valid = v2;
        exp_id  = (v1 && v2) ? int'(!m_last) : (v2 ? 1 : 0);
        ea      = (exp_id == 1) ? req2_a    : req1_a;
        eb      = (exp_id == 1) ? req2_b    : req1_b;
        ec      = (exp_id == 1) ? req2_ctrl : req1_ctrl;
        exp_rdy = (exp_id == 1) ? 2'b01 : 2'b10;
        #1;
        n_vec++;
        if ({req1_ready, req2_ready} !== exp_rdy) begin
            n_err++;
            $display("FAIL %s ready: got %b want %b", tag, {req1_ready, req2_ready}, exp_rdy);
        end
        step();
        // ISSUE cycle
        if (!keep) begin
            if (exp_id == 1) req2_valid = 1'b0; else req1_valid = 1'b0;
        end
        n_vec++;
        if ({fu_start, busy, grant_id, req1_ready, req2_ready} !== {2'b11, exp_id[0], 2'b00}) begin
            n_err++;
            $display("FAIL %s issue_ctl: got %b want %b", tag,
                     {fu_start, busy, grant_id, req1_ready, req2_ready}, {2'b11, exp_id[0], 2'b00});
        end
        n_vec++;
        if ({fu_a, fu_b, fu_ctrl} !== {ea, eb, ec}) begin
            n_err++;
            $display("FAIL %s fu_ops: got %h/%h/%h want %h/%h/%h", tag, fu_a, fu_b, fu_ctrl, ea, eb, ec);
        end
        tmo     = !(dly >= 1 && dly <= 64);
        resp_at = tmo ? 65 : dly + 1;
        for (int k = 1; k < resp_at; k++) begin
            step();
            fu_done   = (k == dly);
            fu_result = (k == dly) ? res : W'($urandom);
            n_vec++;
            if ({fu_start, rsp1_valid, rsp2_valid, busy} !== 4'b0001) begin
                n_err++;
                $display("FAIL %s wait_ctl k=%0d: got %b want 0001", tag, k,
                         {fu_start, rsp1_valid, rsp2_valid, busy});
            end
        end
        step();
        // RESP cycle
        fu_done = 1'b0;
        m_res[exp_id]  = tmo ? '0 : res;
        m_zero[exp_id] = tmo ? 1'b1 : (res == '0);
        m_err[exp_id]  = tmo;
        exp_rsp = (exp_id == 1) ? 2'b01 : 2'b10;
        n_vec++;
        if ({rsp1_valid, rsp2_valid} !== exp_rsp) begin
            n_err++;
            $display("FAIL %s rsp_valid: got %b want %b", tag, {rsp1_valid, rsp2_valid}, exp_rsp);
        end
        n_vec++;
        if ({rsp1_result, rsp1_zero, rsp1_err} !== {m_res[0], m_zero[0], m_err[0]}) begin
            n_err++;
            $display("FAIL %s rsp1_data: got %h/%b/%b want %h/%b/%b", tag, rsp1_result, rsp1_zero,
                     rsp1_err, m_res[0], m_zero[0], m_err[0]);
        end
        n_vec++;
        if ({rsp2_result, rsp2_zero, rsp2_err} !== {m_res[1], m_zero[1], m_err[1]}) begin
            n_err++;
            $display("FAIL %s rsp2_data: got %h/%b/%b want %h/%b/%b", tag, rsp2_result, rsp2_zero,
                     rsp2_err, m_res[1], m_zero[1], m_err[1]);
        end
        step();
        // back in IDLE
        m_last = exp_id[0];
        n_vec++;
        if ({rsp1_valid, rsp2_valid, busy, fu_start} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s idle_ctl: got %b want 0000", tag, {rsp1_valid, rsp2_valid, busy, fu_start});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req1_valid = 1'b1; req2_valid = 1'b1; fu_done = 1'b1;
        fu_result = '1; set_ops(0); set_ops(1);
        step(); step();
        n_vec++;
        if ({req1_ready, req2_ready, rsp1_valid, rsp2_valid, fu_start, busy, grant_id} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {req1_ready, req2_ready, rsp1_valid, rsp2_valid, fu_start, busy, grant_id});
        end
        n_vec++;
        if ({fu_a, fu_b, fu_ctrl, rsp1_result, rsp2_result} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h %h %h %h want all 0", fu_a, fu_b, fu_ctrl,
                     rsp1_result, rsp2_result);
        end
        n_vec++;
        if ({rsp1_zero, rsp1_err, rsp2_zero, rsp2_err} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000", {rsp1_zero, rsp1_err, rsp2_zero, rsp2_err});
        end
        do_reset(1);
    endtask

    task automatic test_single_op();
        req1_a = 32'd5; req1_b = 32'd3; req1_ctrl = 3'b001; req1_valid = 1'b1;
        run_txn(1'b1, 1'b0, 3, 32'd2, 1'b0, "single_op");
    endtask

    task automatic test_alternate();
        do_reset(2);
        for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 2, W'($urandom), 1'b1, "alternate");
        req1_valid = 1'b0; req2_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_txn(1'b0, 1'b1, 1, W'($urandom), 1'b1, "back_to_back");
        req2_valid = 1'b0;
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 0, '0, 1'b0, "timeout");
        run_txn(1'b0, 1'b1, 2, W'($urandom), 1'b0, "after_timeout");
    endtask

    task automatic test_done_edge();
        run_txn(1'b0, 1'b1, 64, 32'h0000_00FF, 1'b0, "done_at_timeout");
        fu_done = 1'b1; fu_result = W'($urandom);
        step();
        fu_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({busy, fu_start, rsp1_valid, rsp2_valid, rsp2_result} !== {4'b0000, m_res[1]}) begin
                n_err++;
                $display("FAIL idle_done: got %b/%h want 0000/%h",
                         {busy, fu_start, rsp1_valid, rsp2_valid}, rsp2_result, m_res[1]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_op();
        set_ops(0); req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({rsp1_valid, rsp2_valid, fu_start, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_wait_ctl: got %b want 0000", {rsp1_valid, rsp2_valid, fu_start, busy});
        end
        step();
        rst = 1'b0; fu_done = 1'b1; fu_result = 32'h1234_5678;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({rsp1_valid, rsp2_valid, busy, rsp1_result} !== {3'b000, W'(0)}) begin
                n_err++;
                $display("FAIL rst_late_done: got %b/%h want 000/0",
                         {rsp1_valid, rsp2_valid, busy}, rsp1_result);
            end
            step();
            fu_done = 1'b0;
        end
        run_txn(1'b1, 1'b1, 2, W'($urandom), 1'b0, "post_reset_tie");
        req2_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int           sel, dly, r;
            bit           v1, v2, keep;
            logic [W-1:0] res;
            sel  = $urandom_range(1, 3);
            v1   = sel[0] | req1_valid;
            v2   = sel[1] | req2_valid;
            r    = $urandom_range(0, 11);
            dly  = (r == 0) ? 0 : (r == 1) ? 64 : $urandom_range(1, 6);
            res  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            keep = 1'($urandom_range(0, 1));
            run_txn(v1, v2, dly, res, keep, "random");
        end
        req1_valid = 1'b0; req2_valid = 1'b0;
        step();
    endtask

    initial begin
        fu_result = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        req2_a = '0; req2_b = '0; req2_ctrl = '0;
        model_reset();
        test_reset();
        test_single_op();
        test_alternate();
        test_back_to_back();
        test_timeout();
        test_done_edge();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
